prog_clock_divider: RTL and testbench
=====================================

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 16, meaning counter/divisor width in bits.
REQ-003 SHALL have parameter DEF_DIV, default 4, meaning per-channel divisor value loaded at reset.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  global count enable; low freezes all counters and outputs.
REQ-007 SHALL have port sync  input  1  single-cycle request to phase-align all channels.
REQ-008 SHALL have port div_wr  input  1  divisor write strobe.
REQ-009 SHALL have port div_ch  input  $clog2(NCH) (min 1)  target channel of the write.
REQ-010 SHALL have port div_val  input  CW  divisor value to write.
REQ-011 SHALL have port mode_in  input  NCH  per-channel mode: 0 = TOGGLE (50% square), 1 = PULSE (one-cycle tick).
REQ-012 SHALL have port clk_out  output  NCH  per-channel divided output, registered.
REQ-013 SHALL have port pend  output  NCH  per-channel flag: a written divisor is waiting to take effect.

Function
REQ-014 Each channel SHALL hold an active divisor D, a pending divisor P, and a counter C (CW bits).
REQ-015 With en=1, C SHALL increment each cycle; when C >= D (terminal), C SHALL return to 0 on the next edge.
REQ-016 In TOGGLE mode, clk_out[i] SHALL invert at each terminal, giving period 2*(D+1) clk cycles.
REQ-017 In PULSE mode, clk_out[i] SHALL be high for exactly the one cycle following each terminal, giving period D+1.
REQ-018 A divisor value of 0 SHALL behave as D=0: TOGGLE inverts every cycle (clk/2) and PULSE is constantly high.
REQ-019 div_wr SHALL load div_val into P[div_ch] and set pend[div_ch]; D SHALL NOT change mid-period.
REQ-020 At a terminal with pend set, D SHALL take P, pend SHALL clear, and C SHALL restart at 0 (glitch-free retune).
REQ-021 A div_wr arriving in the same cycle as that channel's terminal SHALL take effect at that terminal, and pend SHALL remain 0.
REQ-022 A second div_wr to the same channel before its terminal SHALL overwrite P (last write wins).
REQ-023 div_ch >= NCH SHALL be ignored, with no state change.
REQ-024 sync=1 SHALL, on the next edge, clear every C and clk_out, and apply and clear every pending divisor, regardless of en.
REQ-025 A div_wr in the same cycle as sync SHALL be applied immediately to its channel.
REQ-026 Priority SHALL be rst > sync > en=0 (hold) > counting.
REQ-027 While en=0, div_wr SHALL still update P and pend.
REQ-028 A mode_in change SHALL take effect at that channel's next terminal or sync.
REQ-029 The effective mode SHALL be latched alongside D.
REQ-030 In a mode switch to PULSE, clk_out SHALL be forced to 0 first.
REQ-031 clk_out SHALL never glitch: it is driven from a flop only and never used internally as a clock.

Reset
REQ-032 On rst: every C=0, D=P=DEF_DIV, clk_out=0, pend=0, and latched mode = TOGGLE.
REQ-033 rst asserted mid-period SHALL abort immediately, with no partial pulse or extra toggle.
REQ-034 After rst deasserts, the first TOGGLE inversion SHALL occur DEF_DIV+1 enabled cycles later.

Structure
REQ-035 Package clkdiv_pkg SHALL hold the mode enum (MODE_TOGGLE, MODE_PULSE), the DEF_DIV default and the CW default.
REQ-036 Sub-module clkdiv_channel SHALL implement one channel (C, D, P, pend, mode, output flop).
REQ-037 The top level SHALL instantiate NCH copies via generate and decode div_wr/div_ch into per-channel write strobes.

Verification
REQ-038 Reset, defaults, en=1, all TOGGLE -> each clk_out has period 10 cycles, first rise at cycle 5 after reset.
REQ-039 Ch1 PULSE, write div_val=2 mid-period -> pend[1]=1 until terminal, then a one-cycle pulse every 3 cycles, pend[1]=0.
REQ-040 Write ch0=7 in the exact terminal cycle -> pend[0] stays 0, next half-period is 8 cycles.
REQ-041 Different divisors per channel, then sync with a pending write on ch2 -> all counters zero, outputs low, ch2 uses the new D on the same edge.
REQ-042 en=0 for 20 cycles mid-period -> outputs frozen; on resume, the remaining count completes without skew.
REQ-043 rst asserted between clock edges mid-period -> outputs 0 immediately, div_ch=NCH write ignored, and DEF_DIV restored.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int DEF_CW      = 16;
  localparam int DEF_DIV_VAL = 4;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: up-counter with terminal compare, active/pending divisor,
// latched mode and a registered output.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CW      = DEF_CW,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_val,
  input  logic          mode_in,
  output logic          clk_out,
  output logic          pend
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div;
  logic [CW-1:0] pdiv;
  logic          pend_q;
  logic          out_q;
  mode_e         mode_q;
  mode_e         mode_nxt;
  logic          term;

  assign term     = (cnt >= div);
  assign mode_nxt = mode_e'(mode_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      div    <= CW'(DEF_DIV);
      pdiv   <= CW'(DEF_DIV);
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      mode_q <= MODE_TOGGLE;
    end else if (sync) begin
      cnt    <= '0;
      out_q  <= 1'b0;
      pend_q <= 1'b0;
      mode_q <= mode_nxt;
      if (wr) begin
        div  <= wr_val;
        pdiv <= wr_val;
      end else if (pend_q) begin
        div <= pdiv;
      end
    end else begin
      if (wr) pdiv <= wr_val;
      if (en && term) begin
        cnt    <= '0;
        mode_q <= mode_nxt;
        pend_q <= 1'b0;
        if (wr)          div <= wr_val;
        else if (pend_q) div <= pdiv;
        // Entering PULSE from TOGGLE parks the output low for one period.
        if (mode_nxt == MODE_TOGGLE) out_q <= ~out_q;
        else                         out_q <= (mode_q == MODE_PULSE);
      end else begin
        if (wr) pend_q <= 1'b1;
        if (en) begin
          cnt <= cnt + CW'(1);
          if (mode_q == MODE_PULSE) out_q <= 1'b0;
        end
      end
    end
  end

  assign clk_out = out_q;
  assign pend    = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: decodes divisor writes to
// per-channel strobes and instantiates one clkdiv_channel per output.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = DEF_CW,
  parameter int DEF_DIV = DEF_DIV_VAL,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sync,
  input  logic           div_wr,
  input  logic [CHW-1:0] div_ch,
  input  logic [CW-1:0]  div_val,
  input  logic [NCH-1:0] mode_in,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] pend
);

  logic [NCH-1:0] wr_sel;

  // Channel numbers at or above NCH match no strobe and are dropped.
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      assign wr_sel[i] = div_wr && (div_ch == CHW'(i));

      clkdiv_channel #(
        .CW      (CW),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .wr      (wr_sel[i]),
        .wr_val  (div_val),
        .mode_in (mode_in[i]),
        .clk_out (clk_out[i]),
        .pend    (pend[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: table vectors plus directed
// sequences, with expectations queued at drive time and popped after each edge.
module tb_prog_clock_divider;

  localparam int NCH     = 5;
  localparam int CW      = 16;
  localparam int DEF_DIV = 4;
  localparam int CHW     = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           sync = 1'b0;
  logic           div_wr = 1'b0;
  logic [CHW-1:0] div_ch = '0;
  logic [CW-1:0]  div_val = '0;
  logic [NCH-1:0] mode_in = '0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pend;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [NCH-1:0] out;
    logic [NCH-1:0] pnd;
    logic [NCH-1:0] out_m;
    logic [NCH-1:0] pnd_m;
    string          name;
  } exp_t;

  typedef struct {
    logic           en;
    logic           wr;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  val;
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_pend;
  } vec_t;

  exp_t sbq[$];

  prog_clock_divider #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr),
    .div_ch(div_ch), .div_val(div_val), .mode_in(mode_in),
    .clk_out(clk_out), .pend(pend)
  );

  always #5 clk = ~clk;

  function automatic logic tog(input int n, input int p);
    return ((n / p) % 2) != 0;
  endfunction

  task automatic compare_one();
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sbq.pop_front();
    if ((((clk_out ^ e.out) & e.out_m) !== '0) || (((pend ^ e.pnd) & e.pnd_m) !== '0)) begin
      bad++;
      $display("FAIL %s: got clk_out=%b pend=%b, want clk_out=%b pend=%b (masks %b/%b) t=%0t",
               e.name, clk_out, pend, e.out, e.pnd, e.out_m, e.pnd_m, $time);
    end
  endtask

  task automatic step(input logic s_en, input logic s_sync, input logic s_wr,
                      input logic [CHW-1:0] c, input logic [CW-1:0] v,
                      input logic [NCH-1:0] eo, input logic [NCH-1:0] ep,
                      input logic [NCH-1:0] om, input logic [NCH-1:0] pm,
                      input string nm);
    en = s_en; sync = s_sync; div_wr = s_wr; div_ch = c; div_val = v;
    sbq.push_back('{eo, ep, om, pm, nm});
    @(posedge clk);
    #1;
    compare_one();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    @(negedge clk);
    @(negedge clk);
    sbq.push_back('{'0, '0, '1, '1, "reset_state"});
    compare_one();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           vec[20];
    logic [NCH-1:0] eo, ep, om;

    // defaults, all TOGGLE: period 10, first rise on enabled edge 5
    for (int k = 1; k <= 20; k++)
      vec[k-1] = '{1'b1, 1'b0, '0, '0, tog(k, 5) ? '1 : '0, '0};
    mode_in = '0;
    do_reset();
    for (int i = 0; i < 20; i++)
      step(vec[i].en, 1'b0, vec[i].wr, vec[i].ch, vec[i].val,
           vec[i].exp_out, vec[i].exp_pend, '1, '1, $sformatf("default_toggle[%0d]", i + 1));

    // ch1 PULSE, divisor 2 written mid-period
    mode_in = 5'b00010;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      eo = tog(k, 5) ? 5'b11101 : 5'b00000;
      om = 5'b11101;
      if (k >= 6) begin
        om[1] = 1'b1;
        eo[1] = ((k - 5) % 3) == 0;
      end
      ep = (k == 3 || k == 4) ? 5'b00010 : 5'b00000;
      step(1'b1, 1'b0, k == 3, 3'd1, 16'd2, eo, ep, om, '1, $sformatf("pulse_retune[%0d]", k));
    end

    // write at the terminal cycle (ch0=7) and divisor 0 on ch4
    mode_in = '0;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      for (int c = 1; c <= 3; c++) eo[c] = tog(k, 5);
      eo[0] = (k >= 5) ? (((k - 5) / 8) % 2 == 0) : 1'b0;
      eo[4] = (k >= 5) ? (((k - 5) % 2) == 0) : 1'b0;
      ep = (k <= 4) ? 5'b10000 : 5'b00000;
      step(1'b1, 1'b0, (k == 1) || (k == 5), (k == 1) ? 3'd4 : 3'd0,
           (k == 1) ? 16'd0 : 16'd7, eo, ep, '1, '1, $sformatf("term_write[%0d]", k));
    end

    // mixed divisors, then sync with ch2 pending and a same-cycle ch0 write
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      eo[0] = tog(k, 5); eo[2] = tog(k, 5); eo[4] = tog(k, 5);
      eo[1] = (k >= 5) ? (((k - 5) / 3) % 2 == 0) : 1'b0;
      eo[3] = (k >= 5) ? (((k - 5) / 4) % 2 == 0) : 1'b0;
      ep = (k == 1) ? 5'b00010 : (k <= 4) ? 5'b01010 : (k == 8) ? 5'b00100 : 5'b00000;
      step(1'b1, 1'b0, (k == 1) || (k == 2) || (k == 8),
           (k == 1) ? 3'd1 : (k == 2) ? 3'd3 : 3'd2,
           (k == 1) ? 16'd2 : (k == 2) ? 16'd3 : 16'd9, eo, ep, '1, '1,
           $sformatf("pre_sync[%0d]", k));
    end
    for (int m = 0; m <= 24; m++) begin
      eo[0] = tog(m, 2); eo[1] = tog(m, 3); eo[2] = tog(m, 10);
      eo[3] = tog(m, 4); eo[4] = tog(m, 5);
      step(1'b1, m == 0, m == 0, 3'd0, 16'd1, eo, '0, '1, '1, $sformatf("post_sync[%0d]", m));
    end

    // en low for 20 cycles mid-period, with a write to ch3 while frozen
    do_reset();
    for (int n = 1; n <= 7; n++)
      step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, tog(n, 5) ? '1 : '0, '0, '1, '1, $sformatf("pre_freeze[%0d]", n));
    for (int j = 0; j < 20; j++)
      step(1'b0, 1'b0, j == 0, 3'd3, 16'd1, '1, 5'b01000, '1, '1, $sformatf("freeze[%0d]", j));
    for (int n = 8; n <= 22; n++) begin
      eo = tog(n, 5) ? '1 : '0;
      if (n >= 10) eo[3] = (((n - 10) / 2) % 2) != 0;
      ep = (n < 10) ? 5'b01000 : 5'b00000;
      step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, eo, ep, '1, '1, $sformatf("resume[%0d]", n));
    end

    // asynchronous reset mid-period, then out-of-range channel writes
    do_reset();
    for (int k = 1; k <= 6; k++)
      step(1'b1, 1'b0, k == 1, 3'd0, 16'd9, tog(k, 5) ? '1 : '0,
           (k <= 4) ? 5'b00001 : 5'b00000, '1, '1, $sformatf("pre_rst[%0d]", k));
    #2 rst = 1'b1;
    #1;
    sbq.push_back('{'0, '0, '1, '1, "async_rst"});
    compare_one();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 15; k++)
      step(1'b1, 1'b0, (k == 1) || (k == 2), (k == 1) ? 3'd5 : 3'd7, 16'd1,
           tog(k, 5) ? '1 : '0, '0, '1, '1, $sformatf("post_rst[%0d]", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
